// File: rtl/painterengine_gpu_reader_arbiter.sv
// Two-requester front end for a single painterengine_gpu_dma_reader.
// Jobs are latched per requester, granted round-robin, and run one at a time
// by holding the reader's local reset low (IDLE/ARM), releasing it (RUN), then
// re-asserting it (RELEASE) while the completion pulse is reported.
module painterengine_gpu_reader_arbiter #(
  parameter int PARAM_ADDRESS_WIDTH = 32,
  parameter int PARAM_DATA_WIDTH    = 32,
  parameter int PARAM_ARM_CYCLES    = 2
) (
  input  logic                           i_wire_clock,
  input  logic                           i_wire_resetn,

  input  logic                           i_wire_req0_start,
  input  logic [PARAM_ADDRESS_WIDTH-1:0] i_wire_req0_address,
  input  logic [31:0]                    i_wire_req0_length,
  output logic                           o_wire_req0_busy,
  output logic                           o_wire_req0_done,
  output logic                           o_wire_req0_error,
  output logic [PARAM_DATA_WIDTH-1:0]    o_wire_req0_data,
  output logic                           o_wire_req0_data_valid,
  input  logic                           i_wire_req0_data_next,

  input  logic                           i_wire_req1_start,
  input  logic [PARAM_ADDRESS_WIDTH-1:0] i_wire_req1_address,
  input  logic [31:0]                    i_wire_req1_length,
  output logic                           o_wire_req1_busy,
  output logic                           o_wire_req1_done,
  output logic                           o_wire_req1_error,
  output logic [PARAM_DATA_WIDTH-1:0]    o_wire_req1_data,
  output logic                           o_wire_req1_data_valid,
  input  logic                           i_wire_req1_data_next,

  output logic                           o_wire_reader_resetn,
  output logic [PARAM_ADDRESS_WIDTH-1:0] o_wire_reader_address,
  output logic [31:0]                    o_wire_reader_length,
  input  logic                           i_wire_reader_done,
  input  logic                           i_wire_reader_error,
  input  logic [PARAM_DATA_WIDTH-1:0]    i_wire_reader_data,
  input  logic                           i_wire_reader_data_valid,
  output logic                           o_wire_reader_data_next
);

  // A one-cycle arm would still need a 1-bit counter, hence the floor of 1.
  localparam int ARM_CNT_WIDTH = (PARAM_ARM_CYCLES < 2) ? 1 : $clog2(PARAM_ARM_CYCLES + 1);
  localparam logic [ARM_CNT_WIDTH-1:0] ARM_LOAD = ARM_CNT_WIDTH'(PARAM_ARM_CYCLES);
  localparam logic [ARM_CNT_WIDTH-1:0] ARM_LAST = ARM_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_RUN     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                           state_reg, state_next;
  logic                             grant_reg, grant_next;
  logic                             last_grant_reg, last_grant_next;
  logic [ARM_CNT_WIDTH-1:0]         arm_cnt_reg, arm_cnt_next;
  logic [PARAM_ADDRESS_WIDTH-1:0]   reader_address_reg, reader_address_next;
  logic [31:0]                      reader_length_reg, reader_length_next;
  logic [1:0]                       done_reg, done_next;
  logic [1:0]                       error_reg, error_next;

  // Per-requester views of the ports so the request logic can be generated.
  logic [1:0]                       start_vec;
  logic [1:0]                       data_next_vec;
  logic [1:0]                       pending_vec;
  logic [1:0]                       data_valid_vec;
  logic [PARAM_ADDRESS_WIDTH-1:0]   req_address [2];
  logic [31:0]                      req_length  [2];
  logic [PARAM_ADDRESS_WIDTH-1:0]   job_address [2];
  logic [31:0]                      job_length  [2];
  logic                             grant_pick;

  assign start_vec      = {i_wire_req1_start, i_wire_req0_start};
  assign data_next_vec  = {i_wire_req1_data_next, i_wire_req0_data_next};
  assign req_address[0] = i_wire_req0_address;
  assign req_address[1] = i_wire_req1_address;
  assign req_length[0]  = i_wire_req0_length;
  assign req_length[1]  = i_wire_req1_length;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic                           pending_reg;
      logic [PARAM_ADDRESS_WIDTH-1:0] address_reg;
      logic [31:0]                    length_reg;
      logic                           accept;
      logic                           release_hit;

      // busy doubles as the pending flag, so a start while busy is dropped here.
      assign accept      = start_vec[gi] & ~pending_reg;
      assign release_hit = (state_reg == ST_RELEASE) && (grant_reg == 1'(gi));

      // Latch an accepted job; retire it when its RELEASE cycle ends.
      always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
          pending_reg <= 1'b0;
          address_reg <= '0;
          length_reg  <= '0;
        end else if (accept) begin
          pending_reg <= 1'b1;
          address_reg <= req_address[gi];
          length_reg  <= req_length[gi];
        end else if (release_hit) begin
          pending_reg <= 1'b0;
        end
      end

      assign pending_vec[gi]    = pending_reg;
      assign job_address[gi]    = address_reg;
      assign job_length[gi]     = length_reg;
      assign data_valid_vec[gi] = (state_reg == ST_RUN) && (grant_reg == 1'(gi))
                                  && i_wire_reader_data_valid;
    end
  endgenerate

  // Sole pending requester wins; on a tie the one not served last time wins.
  assign grant_pick = (&pending_vec) ? ~last_grant_reg : pending_vec[1];

  // State, grant and reader job registers.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_reg          <= ST_IDLE;
      grant_reg          <= 1'b0;
      last_grant_reg     <= 1'b1;
      arm_cnt_reg        <= '0;
      reader_address_reg <= '0;
      reader_length_reg  <= '0;
      done_reg           <= 2'b00;
      error_reg          <= 2'b00;
    end else begin
      state_reg          <= state_next;
      grant_reg          <= grant_next;
      last_grant_reg     <= last_grant_next;
      arm_cnt_reg        <= arm_cnt_next;
      reader_address_reg <= reader_address_next;
      reader_length_reg  <= reader_length_next;
      done_reg           <= done_next;
      error_reg          <= error_next;
    end
  end

  // Next-state logic; done/error are set on the RUN->RELEASE edge so they
  // appear as registered one-cycle pulses during RELEASE.
  always_comb begin
    state_next          = state_reg;
    grant_next          = grant_reg;
    last_grant_next     = last_grant_reg;
    arm_cnt_next        = arm_cnt_reg;
    reader_address_next = reader_address_reg;
    reader_length_next  = reader_length_reg;
    done_next           = 2'b00;
    error_next          = 2'b00;
    case (state_reg)
      ST_IDLE: begin
        if (|pending_vec) begin
          grant_next          = grant_pick;
          reader_address_next = job_address[grant_pick];
          reader_length_next  = job_length[grant_pick];
          arm_cnt_next        = ARM_LOAD;
          state_next          = ST_ARM;
        end
      end
      ST_ARM: begin
        // The counter reaches zero after exactly PARAM_ARM_CYCLES ARM cycles.
        arm_cnt_next = arm_cnt_reg - ARM_LAST;
        if (arm_cnt_reg == ARM_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_wire_reader_error) begin
          error_next[grant_reg] = 1'b1;
          state_next            = ST_RELEASE;
        end else if (i_wire_reader_done) begin
          done_next[grant_reg] = 1'b1;
          state_next           = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        last_grant_next = grant_reg;
        state_next      = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The reader only runs in RUN; its ready comes from the granted consumer.
  assign o_wire_reader_resetn    = (state_reg == ST_RUN);
  assign o_wire_reader_data_next = (state_reg == ST_RUN) & data_next_vec[grant_reg];
  assign o_wire_reader_address   = reader_address_reg;
  assign o_wire_reader_length    = reader_length_reg;

  assign o_wire_req0_busy       = pending_vec[0];
  assign o_wire_req0_done       = done_reg[0];
  assign o_wire_req0_error      = error_reg[0];
  assign o_wire_req0_data       = i_wire_reader_data;
  assign o_wire_req0_data_valid = data_valid_vec[0];

  assign o_wire_req1_busy       = pending_vec[1];
  assign o_wire_req1_done       = done_reg[1];
  assign o_wire_req1_error      = error_reg[1];
  assign o_wire_req1_data       = i_wire_reader_data;
  assign o_wire_req1_data_valid = data_valid_vec[1];

endmodule

// File: tb/tb_painterengine_gpu_reader_arbiter.sv
// Directed bench for painterengine_gpu_reader_arbiter with a behavioural
// DMA reader model and per-requester beat/pulse monitors.
module tb_painterengine_gpu_reader_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_start = 1'b0, req1_start = 1'b0;
  logic [31:0] req0_address = '0, req1_address = '0;
  logic [31:0] req0_length = '0, req1_length = '0;
  logic        req0_next = 1'b0, req1_next = 1'b0;
  logic        busy0, busy1, done0, done1, err0, err1, valid0, valid1;
  logic [31:0] data0, data1;
  logic        reader_resetn, reader_data_next;
  logic [31:0] reader_address, reader_length;

  logic        rd_done = 1'b0, rd_error = 1'b0, rd_valid = 1'b0;
  logic [31:0] rd_data = '0;
  int          rd_cnt = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          err_at = 0;

  int          compared = 0;
  int          mismatched = 0;
  int          beats0 = 0, beats1 = 0;
  logic [31:0] last0 = '0, last1 = '0;
  int          ev_q[$];  // 0=done0 1=done1 2=error0 3=error1

  always #5 clk = ~clk;

  painterengine_gpu_reader_arbiter #(
    .PARAM_ADDRESS_WIDTH(32),
    .PARAM_DATA_WIDTH(32),
    .PARAM_ARM_CYCLES(2)
  ) dut (
    .i_wire_clock(clk),
    .i_wire_resetn(rst_n),
    .i_wire_req0_start(req0_start),
    .i_wire_req0_address(req0_address),
    .i_wire_req0_length(req0_length),
    .o_wire_req0_busy(busy0),
    .o_wire_req0_done(done0),
    .o_wire_req0_error(err0),
    .o_wire_req0_data(data0),
    .o_wire_req0_data_valid(valid0),
    .i_wire_req0_data_next(req0_next),
    .i_wire_req1_start(req1_start),
    .i_wire_req1_address(req1_address),
    .i_wire_req1_length(req1_length),
    .o_wire_req1_busy(busy1),
    .o_wire_req1_done(done1),
    .o_wire_req1_error(err1),
    .o_wire_req1_data(data1),
    .o_wire_req1_data_valid(valid1),
    .i_wire_req1_data_next(req1_next),
    .o_wire_reader_resetn(reader_resetn),
    .o_wire_reader_address(reader_address),
    .o_wire_reader_length(reader_length),
    .i_wire_reader_done(rd_done),
    .i_wire_reader_error(rd_error),
    .i_wire_reader_data(rd_data),
    .i_wire_reader_data_valid(rd_valid),
    .o_wire_reader_data_next(reader_data_next)
  );

  // Reader model: beats are address+index; done is raised only after the last
  // beat is consumed; length 0 or a job at err_addr reaching beat err_at errors.
  always @(posedge clk) begin
    if (!reader_resetn) begin
      rd_cnt   <= 0;
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      rd_error <= 1'b0;
      rd_data  <= '0;
    end else if (!rd_done && !rd_error) begin
      if (reader_length == 32'd0 || (reader_address == err_addr && rd_cnt == err_at)) begin
        rd_error <= 1'b1;
        rd_valid <= 1'b0;
      end else if (rd_valid) begin
        if (reader_data_next) begin
          if (32'(rd_cnt + 1) == reader_length) begin
            rd_valid <= 1'b0;
            rd_done  <= 1'b1;
          end else begin
            rd_data <= reader_address + 32'(rd_cnt + 1);
          end
          rd_cnt <= rd_cnt + 1;
        end
      end else begin
        rd_valid <= 1'b1;
        rd_data  <= reader_address + 32'(rd_cnt);
      end
    end
  end

  // Monitor on the falling edge: handshakes per requester and pulse order.
  always @(negedge clk) begin
    if (valid0 && req0_next) begin beats0++; last0 = data0; end
    if (valid1 && req1_next) begin beats1++; last1 = data1; end
    if (done0) ev_q.push_back(0);
    if (done1) ev_q.push_back(1);
    if (err0)  ev_q.push_back(2);
    if (err1)  ev_q.push_back(3);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Presents a start for one cycle; returns 1 ns after the accepting edge.
  task automatic start_job(input int n, input logic [31:0] a, input logic [31:0] l);
    if (n == 0) begin req0_start = 1'b1; req0_address = a; req0_length = l; end
    else        begin req1_start = 1'b1; req1_address = a; req1_length = l; end
    tick();
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  task automatic start_both(input logic [31:0] a0, input logic [31:0] l0,
                            input logic [31:0] a1, input logic [31:0] l1);
    req0_start = 1'b1; req0_address = a0; req0_length = l0;
    req1_start = 1'b1; req1_address = a1; req1_length = l1;
    tick();
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while ((busy0 || busy1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = !(busy0 || busy1);
  endtask

  task automatic wait_run(output bit ok);
    int n;
    n = 0;
    while (!reader_resetn && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = reader_resetn;
  endtask

  task automatic test_reset;
    req0_next = 1'b1;
    req1_next = 1'b1;
    rst_n = 1'b0;
    #3;
    compared++;
    if ({busy0, busy1, done0, done1, err0, err1, valid0, valid1} !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_outputs: busy/done/err/valid=%b required 00000000",
               {busy0, busy1, done0, done1, err0, err1, valid0, valid1});
    end
    compared++;
    if (reader_resetn !== 1'b0 || reader_data_next !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_reader_ctrl: resetn=%b data_next=%b required 0 0", reader_resetn, reader_data_next);
    end
    compared++;
    if (reader_address !== 32'h0 || reader_length !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_reader_job: addr=%h len=%h required 0 0", reader_address, reader_length);
    end
    do_reset();
    $display("txn reset done");
  endtask

  task automatic test_single_job;
    int b0, b1, s;
    bit ok;
    do_reset();
    req0_next = 1'b1;
    b0 = beats0; b1 = beats1; s = ev_q.size();
    start_job(0, 32'h1000, 32'd4);
    compared++;
    if (busy0 !== 1'b1 || busy1 !== 1'b0) begin
      mismatched++;
      $display("FAIL single_busy: busy0=%b busy1=%b required 1 0", busy0, busy1);
    end
    tick();
    compared++;
    if (reader_address !== 32'h1000 || reader_length !== 32'd4) begin
      mismatched++;
      $display("FAIL single_job_regs: addr=%h len=%0d required 1000 4", reader_address, reader_length);
    end
    compared++;
    if (reader_resetn !== 1'b0) begin
      mismatched++;
      $display("FAIL single_arm1: resetn=%b required 0", reader_resetn);
    end
    tick();
    compared++;
    if (reader_resetn !== 1'b0) begin
      mismatched++;
      $display("FAIL single_arm2: resetn=%b required 0", reader_resetn);
    end
    tick();
    compared++;
    if (reader_resetn !== 1'b1) begin
      mismatched++;
      $display("FAIL single_run_latency: resetn=%b required 1", reader_resetn);
    end
    wait_idle(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL single_timeout: busy0=%b required 0", busy0);
    end
    compared++;
    if (beats0 - b0 != 4 || beats1 - b1 != 0) begin
      mismatched++;
      $display("FAIL single_beats: req0=%0d req1=%0d required 4 0", beats0 - b0, beats1 - b1);
    end
    compared++;
    if (last0 !== 32'h1003) begin
      mismatched++;
      $display("FAIL single_last_data: %h required 1003", last0);
    end
    compared++;
    if (ev_q.size() - s != 1 || ev_q[ev_q.size() - 1] != 0) begin
      mismatched++;
      $display("FAIL single_pulses: count=%0d required 1 done0", ev_q.size() - s);
    end
    $display("txn req0 addr=1000 len=4 beats=%0d", beats0 - b0);
  endtask

  task automatic test_round_robin;
    int b0, b1, s;
    bit ok;
    do_reset();
    req0_next = 1'b1;
    req1_next = 1'b1;
    b0 = beats0; b1 = beats1; s = ev_q.size();
    start_both(32'h2000, 32'd8, 32'h3000, 32'd2);
    compared++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      mismatched++;
      $display("FAIL rr_busy_both: busy0=%b busy1=%b required 1 1", busy0, busy1);
    end
    tick();
    compared++;
    if (reader_address !== 32'h2000 || reader_length !== 32'd8) begin
      mismatched++;
      $display("FAIL rr_first_grant: addr=%h len=%0d required 2000 8", reader_address, reader_length);
    end
    wait_idle(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL rr_timeout1: busy=%b%b required 00", busy0, busy1);
    end
    compared++;
    if (ev_q.size() - s != 2 || ev_q[s] != 0 || ev_q[s + 1] != 1) begin
      mismatched++;
      $display("FAIL rr_order1: events=%0d required done0 then done1", ev_q.size() - s);
    end
    compared++;
    if (beats0 - b0 != 8 || beats1 - b1 != 2) begin
      mismatched++;
      $display("FAIL rr_beats1: req0=%0d req1=%0d required 8 2", beats0 - b0, beats1 - b1);
    end
    $display("txn pair req0 addr=2000 len=8, req1 addr=3000 len=2");
    // A lone req0 job makes req0 the last grant, so the next tie goes to req1.
    start_job(0, 32'h2400, 32'd1);
    wait_idle(ok);
    $display("txn req0 addr=2400 len=1");
    s = ev_q.size();
    start_both(32'h2800, 32'd3, 32'h3800, 32'd5);
    tick();
    compared++;
    if (reader_address !== 32'h3800 || reader_length !== 32'd5) begin
      mismatched++;
      $display("FAIL rr_second_grant: addr=%h len=%0d required 3800 5", reader_address, reader_length);
    end
    wait_idle(ok);
    compared++;
    if (!ok || ev_q.size() - s != 2 || ev_q[s] != 1 || ev_q[s + 1] != 0) begin
      mismatched++;
      $display("FAIL rr_order2: ok=%0d events=%0d required done1 then done0", ok, ev_q.size() - s);
    end
    $display("txn pair req1 addr=3800 len=5, req0 addr=2800 len=3");
  endtask

  task automatic test_error_path;
    int b0, b1, s, n;
    bit ok;
    do_reset();
    req0_next = 1'b1;
    req1_next = 1'b1;
    err_addr = 32'h5000;
    err_at = 1;
    b0 = beats0; b1 = beats1; s = ev_q.size();
    start_job(1, 32'h5000, 32'd4);
    start_job(0, 32'h6000, 32'd2);
    compared++;
    if (reader_address !== 32'h5000 || busy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL err_grant: addr=%h busy0=%b required 5000 1", reader_address, busy0);
    end
    n = 0;
    while (!err1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (err1 !== 1'b1 || done1 !== 1'b0) begin
      mismatched++;
      $display("FAIL err_pulse: error1=%b done1=%b required 1 0", err1, done1);
    end
    compared++;
    if (reader_resetn !== 1'b0 || reader_data_next !== 1'b0) begin
      mismatched++;
      $display("FAIL err_release: resetn=%b data_next=%b required 0 0", reader_resetn, reader_data_next);
    end
    @(negedge clk);
    compared++;
    if (err1 !== 1'b0 || busy1 !== 1'b0) begin
      mismatched++;
      $display("FAIL err_pulse_width: error1=%b busy1=%b required 0 0", err1, busy1);
    end
    wait_idle(ok);
    compared++;
    if (!ok || ev_q.size() - s != 2 || ev_q[s] != 3 || ev_q[s + 1] != 0) begin
      mismatched++;
      $display("FAIL err_order: ok=%0d events=%0d required error1 then done0", ok, ev_q.size() - s);
    end
    // The beat offered in the cycle the error fires still shows as a handshake.
    compared++;
    if (beats1 - b1 != 2 || beats0 - b0 != 2 || last0 !== 32'h6001) begin
      mismatched++;
      $display("FAIL err_beats: req1=%0d req0=%0d last0=%h required 2 2 6001",
               beats1 - b1, beats0 - b0, last0);
    end
    err_addr = 32'hFFFF_FFFF;
    $display("txn req1 addr=5000 error, req0 addr=6000 len=2");
  endtask

  task automatic test_backpressure;
    int b0, s;
    bit ok;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    req0_next = 1'b0;
    req1_next = 1'b1;
    b0 = beats0; s = ev_q.size();
    start_job(0, 32'h7000, 32'd4);
    wait_run(ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL bp_run_timeout: resetn=%b required 1", reader_resetn);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      req0_next = pat[i];
      req1_next = ~pat[i];
      @(negedge clk);
      compared++;
      if (reader_data_next !== pat[i] || valid1 !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_mirror[%0d]: data_next=%b valid1=%b required %b 0",
                 i, reader_data_next, valid1, pat[i]);
      end
    end
    req0_next = 1'b1;
    wait_idle(ok);
    compared++;
    if (!ok || beats0 - b0 != 4 || last0 !== 32'h7003 || ev_q.size() - s != 1) begin
      mismatched++;
      $display("FAIL bp_complete: ok=%0d beats=%0d last=%h events=%0d required 1 4 7003 1",
               ok, beats0 - b0, last0, ev_q.size() - s);
    end
    $display("txn req0 addr=7000 len=4 backpressured");
  endtask

  task automatic test_start_while_busy;
    int b0, s;
    bit ok;
    do_reset();
    req0_next = 1'b1;
    b0 = beats0; s = ev_q.size();
    start_job(0, 32'h8000, 32'd6);
    wait_run(ok);
    start_job(0, 32'h4000, 32'd1);
    tick();
    compared++;
    if (reader_address !== 32'h8000 || busy0 !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_ignore: addr=%h busy0=%b required 8000 1", reader_address, busy0);
    end
    wait_idle(ok);
    repeat (10) tick();
    compared++;
    if (!ok || busy0 !== 1'b0 || reader_resetn !== 1'b0 || ev_q.size() - s != 1 || beats0 - b0 != 6) begin
      mismatched++;
      $display("FAIL busy_single_run: busy0=%b resetn=%b events=%0d beats=%0d required 0 0 1 6",
               busy0, reader_resetn, ev_q.size() - s, beats0 - b0);
    end
    $display("txn req0 addr=8000 len=6, second start dropped");
  endtask

  task automatic test_async_reset;
    int b1, s;
    bit ok;
    do_reset();
    req0_next = 1'b1;
    req1_next = 1'b1;
    start_job(0, 32'h9000, 32'd20);
    wait_run(ok);
    repeat (3) @(posedge clk);
    s = ev_q.size();
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (reader_resetn !== 1'b0 || busy0 !== 1'b0 || valid0 !== 1'b0 || reader_data_next !== 1'b0) begin
      mismatched++;
      $display("FAIL areset_ctrl: resetn=%b busy0=%b valid0=%b next=%b required 0 0 0 0",
               reader_resetn, busy0, valid0, reader_data_next);
    end
    compared++;
    if (reader_address !== 32'h0 || reader_length !== 32'h0) begin
      mismatched++;
      $display("FAIL areset_job: addr=%h len=%h required 0 0", reader_address, reader_length);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    compared++;
    if (ev_q.size() - s != 0 || busy0 !== 1'b0) begin
      mismatched++;
      $display("FAIL areset_no_pulse: events=%0d busy0=%b required 0 0", ev_q.size() - s, busy0);
    end
    b1 = beats1; s = ev_q.size();
    start_job(1, 32'hA000, 32'd2);
    wait_idle(ok);
    compared++;
    if (!ok || beats1 - b1 != 2 || last1 !== 32'hA001 || ev_q.size() - s != 1 || ev_q[s] != 1) begin
      mismatched++;
      $display("FAIL areset_fresh_job: ok=%0d beats=%0d last=%h events=%0d required 1 2 a001 1",
               ok, beats1 - b1, last1, ev_q.size() - s);
    end
    $display("txn req0 addr=9000 aborted by reset, req1 addr=a000 len=2");
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_error_path();
    test_backpressure();
    test_start_while_busy();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
